// File: rtl/tap_tempo.sv
// tap_tempo: debounces a tap button, times the gap between taps in 1 ms
// ticks and converts it to beats per minute with a bit-serial divider.
module tap_tempo #(
    parameter int TICK_CYCLES    = 50000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int TIMEOUT_TICKS  = 2000,
    parameter int BPM_MIN        = 30,
    parameter int BPM_MAX        = 250,
    parameter int BPM_RESET      = 120
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TAP,
    output logic [7:0] BPM,
    output logic       BPM_VALID,
    output logic       BUSY,
    output logic       ARMED
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0]   DIVIDEND  = 16'd60000;
    localparam logic [11:0]   IVL_MAX   = 12'hFFF;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DIVIDE, S_UPDATE} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [PW-1:0] presc_q;
    logic [DW-1:0] db_q;
    logic          stable_q;
    logic [11:0]   ivl_q;
    logic [11:0]   div_q;
    logic [11:0]   rem_q, rem_d;
    logic [15:0]   dvd_q, dvd_d;
    logic [3:0]    bit_q;
    logic [7:0]    bpm_q;

    logic          tick, tap_evt, timeout, last_bit;
    logic          start_arm, start_div;
    logic [12:0]   trial;
    logic          q_bit;

    // Saturate the 16-bit quotient into the displayable tempo range.
    function automatic logic [7:0] clamp_bpm(input logic [15:0] q);
        logic [7:0] r;
        if (q < 16'(BPM_MIN))
            r = 8'(BPM_MIN);
        else if (q > 16'(BPM_MAX))
            r = 8'(BPM_MAX);
        else
            r = q[7:0];
        return r;
    endfunction

    assign tick     = (presc_q == TICK_LAST);
    // A press is recognised on the tick where a low stable level gives way.
    assign tap_evt  = tick && (sync2_q != stable_q) && (db_q == DB_LAST) && !stable_q;
    assign timeout  = (ivl_q >= 12'(TIMEOUT_TICKS));
    assign last_bit = (bit_q == 4'd15);

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= TAP;
            sync2_q <= sync1_q;
        end
    end

    // Free-running prescaler producing the 1 ms tick strobe.
    always_ff @(posedge CLK) begin
        if (RST || tick)
            presc_q <= '0;
        else
            presc_q <= presc_q + PW'(1);
    end

    // Debounce: the stable level follows the input only after it has
    // disagreed on DEBOUNCE_TICKS consecutive ticks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_q     <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q == stable_q) begin
            db_q <= '0;
        end else if (tick) begin
            if (db_q == DB_LAST) begin
                db_q     <= '0;
                stable_q <= ~stable_q;
            end else begin
                db_q <= db_q + DW'(1);
            end
        end
    end

    // Interval counter: cleared when a measurement starts, counts ticks
    // while armed and sticks at its maximum.
    always_ff @(posedge CLK) begin
        if (RST)
            ivl_q <= '0;
        else if (start_arm || start_div)
            ivl_q <= '0;
        else if (tick && (state_q != S_IDLE) && (ivl_q != IVL_MAX))
            ivl_q <= ivl_q + 12'd1;
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits.
    always_comb begin
        trial = {rem_q, dvd_q[15]};
        q_bit = (trial >= {1'b0, div_q});
        rem_d = q_bit ? 12'(trial - {1'b0, div_q}) : trial[11:0];
        dvd_d = {dvd_q[14:0], q_bit};
    end

    // Divider datapath: load on a new measurement, then one bit per cycle.
    always_ff @(posedge CLK) begin
        if (start_div) begin
            div_q <= (ivl_q == 12'd0) ? 12'd1 : ivl_q;
            rem_q <= '0;
            dvd_q <= DIVIDEND;
            bit_q <= '0;
        end else if (state_q == S_DIVIDE) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            bit_q <= bit_q + 4'd1;
        end
    end

    // BPM register: takes the clamped quotient as the last bit resolves.
    always_ff @(posedge CLK) begin
        if (RST)
            bpm_q <= 8'(BPM_RESET);
        else if ((state_q == S_DIVIDE) && last_bit)
            bpm_q <= clamp_bpm(dvd_d);
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state, measurement start strobes and status outputs.
    always_comb begin
        state_d   = state_q;
        start_arm = 1'b0;
        start_div = 1'b0;
        BUSY      = 1'b0;
        ARMED     = 1'b1;
        BPM_VALID = 1'b0;
        case (state_q)
            S_IDLE: begin
                ARMED = 1'b0;
                if (tap_evt) begin
                    start_arm = 1'b1;
                    state_d   = S_ARMED;
                end
            end
            S_ARMED: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (tap_evt) begin
                    start_div = 1'b1;
                    state_d   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                BUSY = 1'b1;
                if (last_bit)
                    state_d = S_UPDATE;
            end
            S_UPDATE: begin
                BPM_VALID = 1'b1;
                state_d   = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BPM = bpm_q;

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: a timestamp-level model checked every cycle plus
// hand-computed tempo values for directed tap sequences.
module tb_tap_tempo;
    localparam int TC = 10;
    localparam int DB = 2;
    localparam int TO = 2000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TAP = 1'b0;
    logic       TAP3 = 1'b0;
    logic [7:0] BPM, BPM2, BPM3;
    logic       BPM_VALID, BUSY, ARMED;
    logic       BPM_VALID2, BUSY2, ARMED2;
    logic       BPM_VALID3, BUSY3, ARMED3;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int vcnt3 = 0;

    always #5 CLK = ~CLK;

    tap_tempo #(.TICK_CYCLES(TC), .DEBOUNCE_TICKS(DB)) dut (
        .CLK(CLK), .RST(RST), .TAP(TAP), .BPM(BPM),
        .BPM_VALID(BPM_VALID), .BUSY(BUSY), .ARMED(ARMED)
    );

    tap_tempo #(.TICK_CYCLES(TC), .DEBOUNCE_TICKS(DB), .TIMEOUT_TICKS(3000)) dut2 (
        .CLK(CLK), .RST(RST), .TAP(TAP), .BPM(BPM2),
        .BPM_VALID(BPM_VALID2), .BUSY(BUSY2), .ARMED(ARMED2)
    );

    tap_tempo #(.TICK_CYCLES(1), .DEBOUNCE_TICKS(1)) dut3 (
        .CLK(CLK), .RST(RST), .TAP(TAP3), .BPM(BPM3),
        .BPM_VALID(BPM_VALID3), .BUSY(BUSY3), .ARMED(ARMED3)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int clamp_exp(input int q);
        if (q > 250) return 250;
        if (q < 30)  return 30;
        return q;
    endfunction

    // Model state: everything is plain integers and timestamps.
    int m_cyc = 0, m_ph = 0, m_s1 = 0, m_s2 = 0, m_stable = 0, m_dbn = 0;
    int m_ivl = 0, m_div = 1, m_left = 0, m_bpm = 120;
    int m_acc_cyc = 0, m_upd_cyc = 0;
    bit m_armed = 0, m_upd = 0, m_live = 0;
    int mt_ivl_old;
    bit mt_tick, mt_differs, mt_flip, mt_press, mt_was_upd;

    // Model step and per-cycle comparison, just after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            m_live = 1; m_ph = 0; m_s1 = 0; m_s2 = 0; m_stable = 0; m_dbn = 0;
            m_ivl = 0; m_left = 0; m_upd = 0; m_armed = 0; m_bpm = 120;
        end else begin
            mt_tick    = (m_ph == TC - 1);
            mt_differs = (m_s2 != m_stable);
            mt_flip    = mt_tick && mt_differs && (m_dbn + 1 == DB);
            mt_press   = mt_flip && (m_stable == 0);
            m_ph  = mt_tick ? 0 : m_ph + 1;
            if (!mt_differs) m_dbn = 0;
            else if (mt_tick) m_dbn = mt_flip ? 0 : m_dbn + 1;
            if (mt_flip) m_stable = 1 - m_stable;
            m_s2 = m_s1;
            m_s1 = int'(TAP);
            mt_ivl_old = m_ivl;
            mt_was_upd = m_upd;
            m_upd = 0;
            if (m_armed && mt_tick && m_ivl < 4095) m_ivl++;
            if (!m_armed) begin
                if (mt_press) begin m_armed = 1; m_ivl = 0; end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_upd = 1;
                    m_bpm = clamp_exp(60000 / m_div);
                    m_upd_cyc = m_cyc + 1;
                end
            end else if (mt_was_upd) begin
                m_upd = 0;
            end else if (mt_ivl_old >= TO) begin
                m_armed = 0;
            end else if (mt_press) begin
                m_div = (mt_ivl_old == 0) ? 1 : mt_ivl_old;
                m_ivl = 0;
                m_left = 16;
                m_acc_cyc = m_cyc;
            end
        end
        m_cyc++;
        if (m_live) begin
            if (BPM_VALID) vcnt++;
            if (BPM_VALID3) vcnt3++;
            chk("bpm", int'(BPM), m_bpm);
            chk("bpm_valid", int'(BPM_VALID), int'(m_upd));
            chk("busy", int'(BUSY), int'(m_left > 0));
            chk("armed", int'(ARMED), int'(m_armed));
            if (bad > 200) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Clean 5-tick press; the next press begins gap_ticks*TC - trim cycles later.
    task automatic press(input int gap_ticks, input int trim);
        TAP = 1'b1;
        cyc(50);
        TAP = 1'b0;
        cyc(gap_ticks * TC - 50 - trim);
    endtask

    initial begin
        int n;
        int v0;
        RST = 1'b1;
        cyc(3);
        RST = 1'b0;
        chk("rst_bpm", int'(BPM), 120);
        chk("rst_valid", int'(BPM_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_armed", int'(ARMED), 0);
        chk("rst_bpm3", int'(BPM3), 120);
        cyc(600 * TC);
        chk("hold_bpm", int'(BPM), 120);
        chk("hold_armed", int'(ARMED), 0);
        chk("hold_vcnt", vcnt, 0);

        press(500, 0);
        chk("a_armed", int'(ARMED), 1);
        chk("a_vcnt", vcnt, 0);
        press(600, 0);
        chk("b_bpm", int'(BPM), 120);
        chk("b_model_bpm", m_bpm, 120);
        chk("b_vcnt", vcnt, 1);
        chk("b_latency", m_upd_cyc - m_acc_cyc, 17);
        press(1500, 0);
        chk("c_bpm", int'(BPM), 100);
        chk("c_vcnt", vcnt, 2);
        press(200, 0);
        chk("d_bpm", int'(BPM), 40);
        chk("d_model_bpm", m_bpm, 40);
        chk("d_vcnt", vcnt, 3);

        // E, with 1-tick glitches inside its gap
        TAP = 1'b1; cyc(50); TAP = 1'b0; cyc(1000);
        for (int g = 0; g < 3; g++) begin
            TAP = 1'b1; cyc(10); TAP = 1'b0; cyc(40);
        end
        cyc(400 * TC - 50 - 1000 - 150);
        chk("e_bpm_clamp_hi", int'(BPM), 250);
        chk("e_vcnt_glitch", vcnt, 4);

        press(300, 30);
        chk("f_bpm", int'(BPM), 150);
        chk("f_vcnt", vcnt, 5);

        // G, preceded by contact bounce
        for (int k = 0; k < 5; k++) begin
            TAP = 1'b1; cyc(3); TAP = 1'b0; cyc(3);
        end
        TAP = 1'b1; cyc(50); TAP = 1'b0;
        cyc(1900 * TC - 50);
        chk("g_bpm", int'(BPM), 200);
        chk("g_vcnt_bounce", vcnt, 6);
        chk("g_armed_before_to", int'(ARMED), 1);
        cyc(200 * TC);
        chk("g_timeout_armed", int'(ARMED), 0);
        cyc(400 * TC);

        press(500, 0);
        chk("h_rearm_armed", int'(ARMED), 1);
        chk("h_bpm_kept", int'(BPM), 200);
        chk("h_vcnt", vcnt, 6);
        chk("h_dut2_bpm_clamp_lo", int'(BPM2), 30);

        // I: reset in the 8th divide cycle
        v0 = vcnt;
        TAP = 1'b1;
        n = 0;
        while (m_left != 9 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("i_div_cycle8", m_left, 9);
        chk("i_busy_before", int'(BUSY), 1);
        TAP = 1'b0;
        RST = 1'b1;
        cyc(1);
        chk("i_rst_bpm", int'(BPM), 120);
        chk("i_rst_busy", int'(BUSY), 0);
        chk("i_rst_armed", int'(ARMED), 0);
        RST = 1'b0;
        cyc(30);
        chk("i_no_valid", vcnt, v0);

        cyc(20 * TC);
        press(400, 0);
        TAP = 1'b1; cyc(50); TAP = 1'b0; cyc(50);
        chk("k_bpm", int'(BPM), 150);
        chk("k_vcnt", vcnt, v0 + 1);

        // divisor of one on a 1-cycle-tick instance
        TAP3 = 1'b1; cyc(1);
        TAP3 = 1'b0; cyc(1);
        TAP3 = 1'b1; cyc(1);
        TAP3 = 1'b0; cyc(40);
        chk("div1_bpm3", int'(BPM3), 250);
        chk("div1_vcnt3", vcnt3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
